// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: DEPTH-entry in-flight destination scoreboard producing per-source
// forward selects, a load-use / multi-cycle stall and a saturating stall counter.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   IssueValid            instruction in ID/EX attempting to advance
//   IssueRegWrite         issuing instruction writes a register
//   IssueRd[AW]           destination of the issuing instruction
//   IssueLat[LATW]        cycles after stage 1 until its result is forwardable
//   Src[NSRC*AW]          source register indices, source i at [i*AW +: AW]
//   SrcUsed[NSRC]         source i is actually read
//   Flush                 kill the issuing instruction and the stage-1 entry
//   Fwd[NSRC*SW]          per-source select: 0 = register file, k = stage k result
//   Stall                 hold IF/ID and ID/EX, insert a bubble
//   StallCount[16]        saturating count of stalled cycles
module fwd_scoreboard #(
    parameter int AW    = 5,
    parameter int NSRC  = 3,
    parameter int DEPTH = 3,
    parameter int LATW  = 2,
    localparam int SW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 IssueValid,
    input  logic                 IssueRegWrite,
    input  logic [AW-1:0]        IssueRd,
    input  logic [LATW-1:0]      IssueLat,
    input  logic [NSRC*AW-1:0]   Src,
    input  logic [NSRC-1:0]      SrcUsed,
    input  logic                 Flush,
    output logic [NSRC*SW-1:0]   Fwd,
    output logic                 Stall,
    output logic [15:0]          StallCount
);
    localparam logic [LATW-1:0] MAXLAT = LATW'(DEPTH - 1);

    // index j holds pipeline stage j+1
    logic            r_vld [DEPTH];
    logic [AW-1:0]   r_rd  [DEPTH];
    logic [LATW-1:0] r_cnt [DEPTH];
    logic [NSRC-1:0] w_req;
    logic            w_load;
    logic [LATW-1:0] w_lat;

    assign w_load = IssueValid & IssueRegWrite & (IssueRd != '0) & ~Stall & ~Flush;
    assign w_lat  = (IssueLat > MAXLAT) ? MAXLAT : IssueLat;
    assign Stall  = |w_req & ~Flush;

    // Scan oldest to youngest so the youngest matching stage is the last writer.
    always_comb begin
        Fwd   = '0;
        w_req = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (SrcUsed[i] && Src[i*AW +: AW] != '0 && r_vld[k] && r_rd[k] == Src[i*AW +: AW]) begin
                    Fwd[i*SW +: SW] = (r_cnt[k] == '0) ? SW'(k + 1) : '0;
                    w_req[i]        = (r_cnt[k] != '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_vld[j] <= 1'b0;
                r_rd[j]  <= '0;
                r_cnt[j] <= '0;
            end
            StallCount <= '0;
        end else begin
            r_vld[0] <= w_load;
            r_rd[0]  <= IssueRd;
            r_cnt[0] <= w_lat;
            for (int j = 1; j < DEPTH; j++) begin
                // a flushed stage-1 instruction must not survive into stage 2
                r_vld[j] <= r_vld[j-1] & ((j == 1) ? ~Flush : 1'b1);
                r_rd[j]  <= r_rd[j-1];
                r_cnt[j] <= (r_cnt[j-1] == '0) ? '0 : r_cnt[j-1] - 1'b1;
            end
            if (Stall && StallCount != 16'hFFFF)
                StallCount <= StallCount + 16'd1;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vector table plus hand sequences for fwd_scoreboard.
module tb_fwd_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        IssueValid, IssueRegWrite, Flush;
    logic [4:0]  IssueRd;
    logic [1:0]  IssueLat;
    logic [14:0] Src;
    logic [2:0]  SrcUsed;
    logic [5:0]  Fwd;
    logic        Stall;
    logic [15:0] StallCount;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fwd_scoreboard dut (
        .clk(clk), .reset(reset), .IssueValid(IssueValid), .IssueRegWrite(IssueRegWrite),
        .IssueRd(IssueRd), .IssueLat(IssueLat), .Src(Src), .SrcUsed(SrcUsed), .Flush(Flush),
        .Fwd(Fwd), .Stall(Stall), .StallCount(StallCount)
    );

    typedef struct {
        logic        iv, w;
        logic [4:0]  rd;
        logic [1:0]  lat;
        logic [4:0]  s0, s1, s2;
        logic [2:0]  used;
        logic        fl;
        logic [1:0]  f0, f1, f2;
        logic        st;
        logic [15:0] sc;
    } vec_t;

    vec_t q[$];

    task automatic row(input logic iv, w, input logic [4:0] rd, input logic [1:0] lat,
                       input logic [4:0] s0, s1, s2, input logic [2:0] used, input logic fl,
                       input logic [1:0] f0, f1, f2, input logic st, input logic [15:0] sc);
        vec_t v;
        v = '{iv, w, rd, lat, s0, s1, s2, used, fl, f0, f1, f2, st, sc};
        q.push_back(v);
    endtask

    task automatic drive(input logic iv, w, input logic [4:0] rd, input logic [1:0] lat,
                         input logic [4:0] s0, s1, s2, input logic [2:0] used, input logic fl);
        IssueValid = iv; IssueRegWrite = w; IssueRd = rd; IssueLat = lat;
        Src = {s2, s1, s0}; SrcUsed = used; Flush = fl;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        //   iv w rd lat  s0 s1 s2 used fl | f0 f1 f2 st sc
        row(0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        row(1, 1,  5, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        row(1, 0,  0, 0,  5, 0, 0, 1, 0,  1, 0, 0, 0, 0);
        row(1, 1,  6, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        row(1, 1, 10, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        row(1, 0,  0, 0,  6,10, 0, 3, 0,  2, 1, 0, 0, 0);
        row(0, 0,  0, 0,  0, 0, 6, 4, 0,  0, 0, 3, 0, 0);
        row(1, 1,  7, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        row(1, 1,  8, 0,  0, 7, 0, 2, 0,  0, 0, 0, 1, 0);
        row(1, 1,  8, 0,  0, 7, 0, 2, 0,  0, 2, 0, 0, 1);
        row(1, 1,  9, 0,  0, 0, 7, 4, 0,  0, 0, 3, 0, 1);
        row(1, 1,  9, 0,  0, 0, 8, 4, 0,  0, 0, 2, 0, 1);
        row(1, 1,  0, 0,  0, 0, 9, 4, 0,  0, 0, 1, 0, 1);
        row(0, 0,  0, 0,  0, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        row(1, 1, 11, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        row(1, 1, 11, 2,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        row(0, 0,  0, 0, 11, 0, 0, 1, 0,  0, 0, 0, 1, 1);
        row(0, 0,  0, 0, 11, 0, 0, 1, 0,  0, 0, 0, 1, 2);
        row(0, 0,  0, 0, 11, 0, 0, 1, 0,  3, 0, 0, 0, 3);
        row(1, 1, 12, 3,  0, 0, 0, 0, 0,  0, 0, 0, 0, 3);
        row(0, 0,  0, 0,  0,12, 0, 2, 0,  0, 0, 0, 1, 3);
        row(0, 0,  0, 0,  0,12, 0, 2, 0,  0, 0, 0, 1, 4);
        row(0, 0,  0, 0,  0,12, 0, 2, 0,  0, 3, 0, 0, 5);
        row(1, 1, 13, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 5);
        row(0, 0,  0, 0, 13, 0, 0, 2, 0,  0, 0, 0, 0, 5);
        row(1, 1,  3, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 5);
        row(1, 1, 14, 0,  3, 0, 0, 1, 1,  0, 0, 0, 0, 5);
        row(0, 0,  0, 0,  3, 0, 0, 1, 0,  0, 0, 0, 0, 5);
        row(1, 1, 15, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 5);

        foreach (q[i]) begin
            drive(q[i].iv, q[i].w, q[i].rd, q[i].lat, q[i].s0, q[i].s1, q[i].s2, q[i].used, q[i].fl);
            #1;
            chk($sformatf("row%0d Fwd", i), 16'(Fwd), 16'({q[i].f2, q[i].f1, q[i].f0}));
            chk($sformatf("row%0d Stall", i), 16'(Stall), 16'(q[i].st));
            chk($sformatf("row%0d StallCount", i), StallCount, q[i].sc);
            @(negedge clk);
        end

        // reset with a live not-ready entry and a non-zero stall count
        drive(0, 0, 0, 0, 15, 0, 0, 1, 0);
        reset = 1'b1;
        #1;
        chk("pre-reset Stall", 16'(Stall), 16'd1);
        chk("pre-reset StallCount", StallCount, 16'd5);
        @(posedge clk);
        #1;
        chk("post-reset Fwd", 16'(Fwd), 16'd0);
        chk("post-reset Stall", 16'(Stall), 16'd0);
        chk("post-reset StallCount", StallCount, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle StallCount", StallCount, 16'd0);

        // two-cycle-latency producer: consumer must stall exactly twice then see stage 3
        @(negedge clk);
        drive(1, 1, 20, 2, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 21, 0, 0, 0, 20, 4, 0);
        #1;
        n = 0;
        while (Stall && n < 10) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("lat2 stall cycles", 16'(n), 16'd2);
        chk("lat2 Fwd", 16'(Fwd), 16'({2'd3, 2'd0, 2'd0}));
        chk("lat2 StallCount", StallCount, 16'd2);

        // reset and flush together: reset clears the count, flush changes nothing extra
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset+flush StallCount", StallCount, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
